// File: rtl/multicycle_control_fsm.sv
// Multi-cycle MIPS control unit: accepts one instruction per valid/ready handshake and
// sequences FETCH/DECODE/EXEC/ADDR/MEM/WB/BRANCH, driving datapath controls per state.
module multicycle_control_fsm #(
  parameter int INSTR_W    = 32,
  parameter int MUL_CYCLES = 4,
  parameter int ALUOP_W    = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               instr_valid,
  input  logic [INSTR_W-1:0] instr,
  output logic               instr_ready,
  input  logic               mem_ready,
  output logic               ir_write,
  output logic               pc_write,
  output logic               alu_src,
  output logic [ALUOP_W-1:0] alu_op,
  output logic               reg_dst,
  output logic               reg_write,
  output logic               mem_read,
  output logic               mem_write,
  output logic               mem_to_reg,
  output logic               branch,
  output logic               illegal,
  output logic [2:0]         state
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_ADDR   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_BRANCH = 3'd6
  } state_t;

  localparam int CNT_W = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;
  localparam logic [CNT_W-1:0] MUL_LAST = CNT_W'(MUL_CYCLES - 1);

  localparam logic [ALUOP_W-1:0] OP_IDLE = ALUOP_W'(0);
  localparam logic [ALUOP_W-1:0] OP_ADD  = ALUOP_W'(1);
  localparam logic [ALUOP_W-1:0] OP_SUB  = ALUOP_W'(2);
  localparam logic [ALUOP_W-1:0] OP_MUL  = ALUOP_W'(3);

  state_t             state_q;
  logic [INSTR_W-1:0] ir_q;
  logic [CNT_W-1:0]   mul_cnt_q;

  logic [5:0] opcode;
  logic [5:0] funct;
  logic       is_rtype;
  logic       is_add;
  logic       is_sub;
  logic       is_mul;
  logic       is_lw;
  logic       is_sw;
  logic       is_beq;
  logic       is_illegal;
  logic       handshake;
  logic       unused_ir;

  // Register-specifier fields are carried in IR for the datapath but not decoded here.
  assign unused_ir = ^ir_q[INSTR_W-7:6];

  always_comb begin
    opcode     = ir_q[INSTR_W-1 -: 6];
    funct      = ir_q[5:0];
    is_rtype   = (opcode == 6'b000001);
    is_add     = is_rtype && (funct == 6'b100000);
    is_sub     = is_rtype && (funct == 6'b100010);
    is_mul     = is_rtype && (funct == 6'b110010);
    is_lw      = (opcode == 6'b000010);
    is_sw      = (opcode == 6'b000011);
    is_beq     = (opcode == 6'b000100);
    is_illegal = !(is_add || is_sub || is_mul || is_lw || is_sw || is_beq);
  end

  assign instr_ready = rst_n && (state_q == S_FETCH);
  assign handshake   = instr_valid && instr_ready;
  assign state       = state_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_FETCH;
      ir_q      <= '0;
      mul_cnt_q <= '0;
    end else begin
      case (state_q)
        S_FETCH: begin
          if (handshake) begin
            ir_q    <= instr;
            state_q <= S_DECODE;
          end
        end
        S_DECODE: begin
          if (is_illegal)    state_q <= S_FETCH;
          else if (is_rtype) state_q <= S_EXEC;
          else if (is_beq)   state_q <= S_BRANCH;
          else               state_q <= S_ADDR;
        end
        S_EXEC: begin
          // MUL occupies EXEC for MUL_CYCLES cycles; the counter is left at zero on exit.
          if (is_mul && (mul_cnt_q != MUL_LAST)) begin
            mul_cnt_q <= mul_cnt_q + 1'b1;
          end else begin
            mul_cnt_q <= '0;
            state_q   <= S_WB;
          end
        end
        S_ADDR:   state_q <= S_MEM;
        S_MEM: begin
          if (mem_ready) state_q <= is_lw ? S_WB : S_FETCH;
        end
        S_WB:     state_q <= S_FETCH;
        S_BRANCH: state_q <= S_FETCH;
        default:  state_q <= S_FETCH;
      endcase
    end
  end

  always_comb begin
    ir_write   = handshake;
    pc_write   = handshake;
    alu_src    = 1'b0;
    alu_op     = OP_IDLE;
    reg_dst    = 1'b0;
    reg_write  = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    mem_to_reg = 1'b0;
    branch     = 1'b0;
    illegal    = 1'b0;
    if (rst_n) begin
      case (state_q)
        S_DECODE: illegal = is_illegal;
        S_EXEC: begin
          if (is_mul)      alu_op = OP_MUL;
          else if (is_sub) alu_op = OP_SUB;
          else             alu_op = OP_ADD;
        end
        S_ADDR: begin
          alu_src = 1'b1;
          alu_op  = OP_ADD;
        end
        S_MEM: begin
          mem_read  = is_lw;
          mem_write = is_sw;
        end
        S_WB: begin
          reg_write  = 1'b1;
          reg_dst    = is_rtype;
          mem_to_reg = is_lw;
        end
        S_BRANCH: begin
          alu_op = OP_SUB;
          branch = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Scoreboard bench for multicycle_control_fsm: stimulus pushes per-cycle expected controls,
// a negedge monitor pops and compares them whenever the FSM is busy or handshaking.
module tb_multicycle_control_fsm;
  localparam int MULC = 4;
  localparam int K_ADD = 0, K_SUB = 1, K_MUL = 2, K_LW = 3, K_SW = 4, K_BEQ = 5, K_ILL = 6;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        instr_valid;
  logic [31:0] instr;
  logic        mem_ready;
  logic        instr_ready, ir_write, pc_write, alu_src;
  logic [3:0]  alu_op;
  logic        reg_dst, reg_write, mem_read, mem_write, mem_to_reg, branch, illegal;
  logic [2:0]  state;

  multicycle_control_fsm #(.INSTR_W(32), .MUL_CYCLES(MULC), .ALUOP_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .instr(instr),
    .instr_ready(instr_ready), .mem_ready(mem_ready), .ir_write(ir_write),
    .pc_write(pc_write), .alu_src(alu_src), .alu_op(alu_op), .reg_dst(reg_dst),
    .reg_write(reg_write), .mem_read(mem_read), .mem_write(mem_write),
    .mem_to_reg(mem_to_reg), .branch(branch), .illegal(illegal), .state(state)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0]  st;
    logic [13:0] ctl;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  bit   mon_en = 1'b0;

  wire [13:0] ctl_now = {instr_ready, ir_write, pc_write, alu_src, alu_op, reg_dst,
                         reg_write, mem_read, mem_write, mem_to_reg, branch, illegal};

  function automatic logic [13:0] mk(input logic rdy, input logic hs, input logic src,
                                     input logic [3:0] op, input logic dst, input logic rw,
                                     input logic mr, input logic mw, input logic m2r,
                                     input logic br, input logic ill);
    return {rdy, hs, hs, src, op, dst, rw, mr, mw, m2r, br, ill};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h, required %h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Expected per-cycle trace from the handshake cycle to the last cycle before FETCH.
  task automatic push_expect(input int kind, input int waits);
    exp_t e;
    logic [3:0] op;
    e = {3'd0, mk(1, 1, 0, 4'd0, 0, 0, 0, 0, 0, 0, 0)};
    exp_q.push_back(e);
    if (kind == K_ILL) begin
      e = {3'd1, mk(0, 0, 0, 4'd0, 0, 0, 0, 0, 0, 0, 1)};
      exp_q.push_back(e);
      return;
    end
    e = {3'd1, mk(0, 0, 0, 4'd0, 0, 0, 0, 0, 0, 0, 0)};
    exp_q.push_back(e);
    case (kind)
      K_ADD, K_SUB, K_MUL: begin
        op = (kind == K_ADD) ? 4'd1 : (kind == K_SUB) ? 4'd2 : 4'd3;
        for (int i = 0; i < ((kind == K_MUL) ? MULC : 1); i++) begin
          e = {3'd2, mk(0, 0, 0, op, 0, 0, 0, 0, 0, 0, 0)};
          exp_q.push_back(e);
        end
        e = {3'd5, mk(0, 0, 0, 4'd0, 1, 1, 0, 0, 0, 0, 0)};
        exp_q.push_back(e);
      end
      K_LW, K_SW: begin
        e = {3'd3, mk(0, 0, 1, 4'd1, 0, 0, 0, 0, 0, 0, 0)};
        exp_q.push_back(e);
        for (int i = 0; i <= waits; i++) begin
          e = {3'd4, mk(0, 0, 0, 4'd0, 0, 0, kind == K_LW, kind == K_SW, 0, 0, 0)};
          exp_q.push_back(e);
        end
        if (kind == K_LW) begin
          e = {3'd5, mk(0, 0, 0, 4'd0, 0, 1, 0, 0, 1, 0, 0)};
          exp_q.push_back(e);
        end
      end
      default: begin
        e = {3'd6, mk(0, 0, 0, 4'd2, 0, 0, 0, 0, 0, 1, 0)};
        exp_q.push_back(e);
      end
    endcase
  endtask

  exp_t cur;
  always @(negedge clk) begin
    if (mon_en && rst_n) begin
      if (state != 3'd0 || (instr_valid && instr_ready)) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_cycle: got state %0d ctl %h, required idle FETCH", state, ctl_now);
        end else begin
          cur = exp_q.pop_front();
          check("cycle", {15'b0, state, ctl_now}, {15'b0, cur.st, cur.ctl});
        end
      end else begin
        check("idle_fetch", {15'b0, state, ctl_now},
              {15'b0, 3'd0, mk(1, 0, 0, 4'd0, 0, 0, 0, 0, 0, 0, 0)});
      end
    end
  end

  task automatic wait_fetch(input string name);
    for (int i = 0; i < 50 && state != 3'd0; i++) begin
      @(posedge clk); #1;
    end
    if (state != 3'd0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s_timeout: got state %0d, required 0", name, state);
    end
  endtask

  // Called #1 after a rising edge with the FSM in FETCH; returns the same way.
  task automatic issue(input string name, input logic [31:0] w, input int kind,
                       input int waits, input bit keep);
    instr       = w;
    instr_valid = 1'b1;
    mem_ready   = (waits == 0);
    push_expect(kind, waits);
    $display("txn %s instr=%h mem_waits=%0d", name, w, waits);
    @(posedge clk); #1;
    if (!keep) instr_valid = 1'b0;
    if (kind == K_LW || kind == K_SW) begin
      repeat (2) begin @(posedge clk); #1; end
      repeat (waits) begin @(posedge clk); #1; end
      mem_ready = 1'b1;
    end
    wait_fetch(name);
  endtask

  localparam logic [31:0] I_ADD = 32'b000001_00011_00100_01001_00000_100000;
  localparam logic [31:0] I_SUB = 32'b000001_00011_00100_01001_00000_100010;
  localparam logic [31:0] I_MUL = 32'b000001_00001_00010_01000_00000_110010;
  localparam logic [31:0] I_SW  = 32'b000011_00110_01010_0000000000000000;
  localparam logic [31:0] I_LW  = 32'b000010_00110_01010_0000000000000100;
  localparam logic [31:0] I_BEQ = 32'b000100_00001_00010_0000000000000011;
  localparam logic [31:0] I_IOP = 32'b111111_00001_00010_0000000000000000;
  localparam logic [31:0] I_IFN = 32'b000001_00001_00010_00011_00000_000111;

  initial begin
    rst_n = 1'b0; instr_valid = 1'b0; instr = '0; mem_ready = 1'b0;
    #1;
    check("reset_state", {29'b0, state}, 32'd0);
    check("reset_outputs", {18'b0, ctl_now}, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("release_ready", {31'b0, instr_ready}, 32'd1);

    // SW stalled in MEM, then reset asserted between clock edges.
    @(posedge clk); #1;
    $display("txn sw_reset instr=%h", I_SW);
    instr = I_SW; instr_valid = 1'b1; mem_ready = 1'b0;
    @(posedge clk); #1;
    instr_valid = 1'b0;
    for (int i = 0; i < 10 && state != 3'd4; i++) begin @(posedge clk); #1; end
    check("pre_reset_state", {29'b0, state}, 32'd4);
    check("pre_reset_mem_write", {31'b0, mem_write}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("async_reset_mem_write", {31'b0, mem_write}, 32'd0);
    check("async_reset_state", {29'b0, state}, 32'd0);
    check("async_reset_ready", {31'b0, instr_ready}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("rerelease_ready", {31'b0, instr_ready}, 32'd1);
    check("rerelease_state", {29'b0, state}, 32'd0);
    @(posedge clk); #1;
    mon_en = 1'b1;

    issue("add", I_ADD, K_ADD, 0, 1'b0);
    issue("mul", I_MUL, K_MUL, 0, 1'b0);
    issue("sub", I_SUB, K_SUB, 0, 1'b0);
    issue("sw_stall3", I_SW, K_SW, 3, 1'b0);
    issue("sw_fast", I_SW, K_SW, 0, 1'b0);
    issue("lw_b2b", I_LW, K_LW, 0, 1'b1);
    issue("beq_b2b", I_BEQ, K_BEQ, 0, 1'b0);
    issue("lw_stall2", I_LW, K_LW, 2, 1'b0);
    issue("ill_opcode", I_IOP, K_ILL, 0, 1'b0);
    issue("ill_funct", I_IFN, K_ILL, 0, 1'b0);
    issue("add_last", I_ADD, K_ADD, 0, 1'b0);

    repeat (3) @(posedge clk);
    #1;
    check("scoreboard_drain", exp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, required $finish before 100000");
    $fatal(1);
  end
endmodule
